// File: rtl/bitwise_op_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bitwise_op_fifo_pkg
//   Shared definitions for the bitwise-op FIFO block: the 2-bit op encoding
//   used on the op / c_op ports. Imported by the RTL and by the testbench.
// -----------------------------------------------------------------------------
package bitwise_op_fifo_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

endpackage : bitwise_op_fifo_pkg

// File: rtl/bitwise_op_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Generic single-clock FIFO with occupancy count. Pushes when full and pops
//   when empty are ignored, so the caller may drive raw requests.
//
// Ports
//   clk      in   1     clock, all state on posedge
//   rst_n    in   1     synchronous active-low reset (pointers/count only)
//   i_push   in   1     write i_wdata at the tail
//   i_pop    in   1     drop the head entry
//   i_wdata  in   DW    data to write
//   o_rdata  out  DW    entry at the head (raw storage, meaningful when !o_empty)
//   o_count  out  CW    entries stored
//   o_full   out  1     o_count == DEPTH
//   o_empty  out  1     o_count == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DW    = 10,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == {CW{1'b0}});
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage write; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap at DEPTH-1 by compare so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? {PW{1'b0}} : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? {PW{1'b0}} : r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: holds when push and pop coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/bitwise_op_fifo.sv
// -----------------------------------------------------------------------------
// bitwise_op_fifo
//   Computes op(a,b) per bit (AND/OR/XOR/NAND) on each accepted input beat and
//   queues {op, result} in a DEPTH-entry FIFO drained by a valid/ready consumer.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      room for a beat (depends on registered count only)
//   a, b       in   WIDTH  operands
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  out  1      head holds a result
//   out_ready  in   1      consumer takes the head
//   c          out  WIDTH  result at head (0 when empty)
//   c_op       out  2      op that produced c (0 when empty)
//   count      out  CW     entries stored
// -----------------------------------------------------------------------------
module bitwise_op_fifo
    import bitwise_op_fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [1:0]       c_op,
    output logic [CW-1:0]    count
);

    localparam int DW = WIDTH + 2;

    logic [WIDTH-1:0] w_result;
    logic [DW-1:0]    w_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Per-lane operation select; op is only captured when the beat is pushed.
    always_comb begin
        w_result = {WIDTH{1'b0}};
        case (op)
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_NAND: w_result = ~(a & b);
            default: w_result = a & b;
        endcase
    end

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({op, w_result}),
        .o_rdata (w_rdata),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Storage is never cleared, so mask the head to zero while empty.
    assign c    = w_empty ? {WIDTH{1'b0}} : w_rdata[WIDTH-1:0];
    assign c_op = w_empty ? 2'b00         : w_rdata[DW-1:WIDTH];

endmodule : bitwise_op_fifo

// File: tb/tb_bitwise_op_fifo.sv
`timescale 1ns/1ps
module tb_bitwise_op_fifo;
    import bitwise_op_fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  c;
    logic [1:0]    c_op;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] mq[$];

    typedef struct {
        logic       v;
        logic [7:0] va;
        logic [7:0] vb;
        logic [1:0] vop;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [2:0] e_cnt;
        logic [7:0] e_c;
        logic [1:0] e_cop;
    } vec_t;

    vec_t tv[21];

    always #5 clk = ~clk;

    bitwise_op_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_op      (c_op),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] calc(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // One clock cycle checked against the queue model.
    task automatic mcycle(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [1:0] iop, input logic ordy, output logic acc);
        logic       mpush;
        logic       mpop;
        logic [9:0] head;
        in_valid  = v;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        @(negedge clk);
        head = (mq.size() != 0) ? mq[0] : 10'd0;
        chk("in_ready",  in_ready,  mq.size() != D);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("count",     count,     mq.size());
        chk("c",         c,         head[7:0]);
        chk("c_op",      c_op,      head[9:8]);
        mpush = v && (mq.size() != D) && rst_n;
        mpop  = ordy && (mq.size() != 0) && rst_n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (mpop)  void'(mq.pop_front());
            if (mpush) mq.push_back({iop, calc(iop, ia, ib)});
        end
        acc = mpush;
    endtask

    task automatic drain(input string name);
        logic acc;
        int   guard;
        guard = 0;
        while (mq.size() != 0 && guard < 40) begin
            mcycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, acc);
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_drained_count"}, count, 32'd0);
        chk({name, "_drained_ov"},    out_valid, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   sent;
        int   guard;
        logic ordy_t;

        // op table: F0/3C through all four ops, then fill/full and concurrent push/pop
        tv[0]  = '{1'b1, 8'hF0, 8'h3C, OP_AND,  1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 2'd0};
        tv[1]  = '{1'b1, 8'hF0, 8'h3C, OP_OR,   1'b1, 1'b1, 1'b1, 3'd1, 8'h30, 2'd0};
        tv[2]  = '{1'b1, 8'hF0, 8'h3C, OP_XOR,  1'b1, 1'b1, 1'b1, 3'd1, 8'hFC, 2'd1};
        tv[3]  = '{1'b1, 8'hF0, 8'h3C, OP_NAND, 1'b1, 1'b1, 1'b1, 3'd1, 8'hCC, 2'd2};
        tv[4]  = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b1, 1'b1, 1'b1, 3'd1, 8'hCF, 2'd3};
        tv[5]  = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 2'd0};
        tv[6]  = '{1'b1, 8'h11, 8'hFF, OP_AND,  1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 2'd0};
        tv[7]  = '{1'b1, 8'h22, 8'hFF, OP_AND,  1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 2'd0};
        tv[8]  = '{1'b1, 8'h33, 8'hFF, OP_AND,  1'b0, 1'b1, 1'b1, 3'd2, 8'h11, 2'd0};
        tv[9]  = '{1'b1, 8'h44, 8'hFF, OP_AND,  1'b0, 1'b1, 1'b1, 3'd3, 8'h11, 2'd0};
        tv[10] = '{1'b1, 8'h55, 8'hFF, OP_AND,  1'b0, 1'b0, 1'b1, 3'd4, 8'h11, 2'd0};
        tv[11] = '{1'b1, 8'h55, 8'hFF, OP_AND,  1'b1, 1'b0, 1'b1, 3'd4, 8'h11, 2'd0};
        tv[12] = '{1'b1, 8'h55, 8'hFF, OP_AND,  1'b0, 1'b1, 1'b1, 3'd3, 8'h22, 2'd0};
        tv[13] = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b0, 1'b0, 1'b1, 3'd4, 8'h22, 2'd0};
        tv[14] = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b1, 1'b0, 1'b1, 3'd4, 8'h22, 2'd0};
        tv[15] = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b1, 1'b1, 1'b1, 3'd3, 8'h33, 2'd0};
        tv[16] = '{1'b1, 8'h66, 8'h0F, OP_OR,   1'b1, 1'b1, 1'b1, 3'd2, 8'h44, 2'd0};
        tv[17] = '{1'b1, 8'h77, 8'h70, OP_XOR,  1'b1, 1'b1, 1'b1, 3'd2, 8'h55, 2'd0};
        tv[18] = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b1, 1'b1, 1'b1, 3'd2, 8'h6F, 2'd1};
        tv[19] = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b1, 1'b1, 1'b1, 3'd1, 8'h07, 2'd2};
        tv[20] = '{1'b0, 8'h00, 8'h00, OP_AND,  1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 2'd0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        op        = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("reset_in_ready",  in_ready,  32'd1);
        chk("reset_out_valid", out_valid, 32'd0);
        chk("reset_count",     count,     32'd0);
        chk("reset_c",         c,         32'd0);
        chk("reset_c_op",      c_op,      32'd0);
        @(posedge clk);
        #1;

        // Table-driven: ops, fill to full, pop frees slot, concurrent push/pop
        for (int i = 0; i < 21; i++) begin
            in_valid  = tv[i].v;
            a         = tv[i].va;
            b         = tv[i].vb;
            op        = tv[i].vop;
            out_ready = tv[i].ordy;
            @(negedge clk);
            chk($sformatf("tv%0d_in_ready", i),  in_ready,  tv[i].e_ir);
            chk($sformatf("tv%0d_out_valid", i), out_valid, tv[i].e_ov);
            chk($sformatf("tv%0d_count", i),     count,     tv[i].e_cnt);
            chk($sformatf("tv%0d_c", i),         c,         tv[i].e_c);
            chk($sformatf("tv%0d_c_op", i),      c_op,      tv[i].e_cop);
            @(posedge clk);
            #1;
        end

        // Wrap: 10 beats with out_ready toggling 1010...
        sent   = 0;
        guard  = 0;
        ordy_t = 1'b1;
        while (sent < 10 && guard < 100) begin
            mcycle(1'b1, 8'(sent * 37 + 5), 8'hA5, 2'(sent % 4), ordy_t, acc);
            if (acc) sent++;
            ordy_t = ~ordy_t;
            guard++;
        end
        chk("wrap_all_sent", sent, 32'd10);
        drain("wrap");

        // Reset mid-operation with three entries queued
        for (int i = 0; i < 3; i++) begin
            mcycle(1'b1, 8'(8'h40 + i), 8'hFF, OP_XOR, 1'b0, acc);
        end
        rst_n = 1'b0;
        mcycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, acc);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_count",     count,     32'd0);
        chk("midrst_out_valid", out_valid, 32'd0);
        chk("midrst_in_ready",  in_ready,  32'd1);
        chk("midrst_c",         c,         32'd0);
        @(posedge clk);
        #1;
        mcycle(1'b1, 8'h5A, 8'h0F, OP_NAND, 1'b0, acc);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_new_head_c",    c,     32'hF5);
        chk("midrst_new_head_op",   c_op,  32'd3);
        chk("midrst_new_head_cnt",  count, 32'd1);
        @(posedge clk);
        #1;
        drain("midrst");

        // Random traffic against the queue model
        for (int i = 0; i < 1000; i++) begin
            mcycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bitwise_op_fifo
